sad_min_search: RTL and testbench
=================================

# sad_min_search

Sequential stage directly downstream of the 2x2 sum-of-absolute-differences block in the motion-estimation path. Accumulates the 10-bit 2x2 SAD values of one candidate block, then compares the candidate total against the running best. After the last candidate it holds the minimum SAD and its candidate index until the consumer accepts them.

## Interface
- SUBBLKS, 4: 2x2 SADs summed per candidate (≥1)
- NUM_CAND, 16: candidates per search (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin new search; honoured only in IDLE
- sad_in  in  10  2x2 SAD from upstream stage
- in_valid  in  1  sad_in valid
- in_ready  out  1  stage accepts sad_in (beat = in_valid & in_ready)
- best_sad  out  ACC_W  minimum candidate total; ACC_W = 10 + clog2(SUBBLKS)
- best_idx  out  IDX_W  index of winning candidate; IDX_W = max(1, clog2(NUM_CAND))
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, out_valid=0. On start=1, go to ACCUM and clear acc, sub_cnt, cand_cnt.
- ACCUM: in_ready=1. Each beat adds sad_in to acc and increments sub_cnt.
- On the beat with sub_cnt==SUBBLKS-1, form total = acc + sad_in and evaluate it the same cycle:
  - Candidate 0: always loads best_sad/best_idx.
  - Later candidates: replace only if total < best_sad (strict). Ties keep the lower index.
  - On the same edge, acc and sub_cnt clear and cand_cnt increments.
- After the beat that completes candidate NUM_CAND-1, go to DONE.
- DONE: out_valid=1; best_sad/best_idx stable. When out_valid & out_ready, go to IDLE.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored (no beat).
- Widths: acc is ACC_W and never overflows (SUBBLKS*1020 fits). Comparison is unsigned.
- rst mid-search aborts immediately. Partial results are discarded, no out_valid.

## Timing
- Reset values: in_ready=0, out_valid=0, best_sad=0, best_idx=0, state IDLE, all counters 0.
- in_ready and out_valid are decoded from registered state only; no combinational input-to-output path.
- start accepted at edge N means in_ready=1 from cycle N+1.
- Latency: out_valid asserts in the cycle after the final beat's edge.
- Minimum search length is NUM_CAND*SUBBLKS beats.
- in_valid gaps stall accumulation with no state loss.
- out_ready=1 with out_valid=1: DONE→IDLE at that edge. A start in the following cycle is honoured.
- start in the same cycle as the DONE handshake is ignored.

## Configuration
- SAD_MIN_ZERO_EXIT_EN
- Defined: a candidate total of 0 is an exact match. It loads best (0, its index) and goes straight to DONE. Remaining upstream beats are not accepted.
- Undefined: all NUM_CAND candidates are always processed, and a zero total is treated like any other value.

## Structure
- Shared package sad_pkg holds:
  - SAD_W=10
  - the state enum (IDLE/ACCUM/DONE)
  - the ACC_W/IDX_W width functions
- The 2x2 SAD stage also imports SAD_W from sad_pkg.
- One sub-module, sad_min_cmp: combinational total-vs-best compare with the first-candidate override, producing a take_new flag.
- Counters and FSM stay in the top module.

## Test plan
- SUBBLKS=4, NUM_CAND=4; candidate SADs {10,10,10,10},{5,5,5,5},{5,5,5,5},{100,0,0,0} -> best_sad=20, best_idx=1 (tie with candidate 2 keeps the lower index); out_valid one cycle after the 16th beat.
- Every sad_in=1020, SUBBLKS=4 -> best_sad=4080 (no overflow), best_idx=0.
- in_valid toggled every other cycle, out_ready held 0 for 5 cycles -> same result as back-to-back; outputs stable while held; IDLE after the handshake.
- rst asserted after 7 beats, then a new start with all sad_in=3 -> no out_valid from the aborted search; new result best_sad=12, best_idx=0.
- start pulsed during ACCUM and during DONE -> no effect; cand_cnt continues.
- With SAD_MIN_ZERO_EXIT_EN, candidate 2 all zeros -> best_sad=0, best_idx=2, out_valid right after candidate 2, in_ready=0. Without the macro, all 4 candidates are consumed, with the same best.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared definitions for the motion-estimation SAD path: SAD width, search FSM
// states and the accumulator/index width helpers.
package sad_pkg;

  localparam int unsigned SAD_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } sad_state_e;

  // Accumulator wide enough for subblks full-scale SADs without overflow.
  function automatic int unsigned acc_w(input int unsigned subblks);
    return SAD_W + $clog2(subblks);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_cand);
    return (num_cand > 1) ? $clog2(num_cand) : 1;
  endfunction

endpackage

// File: rtl/sad_min_search_if.sv
// Upstream SAD stream and downstream best-match result bundle of sad_min_search.
interface sad_min_search_if #(
  parameter int unsigned SUBBLKS  = 4,
  parameter int unsigned NUM_CAND = 16
);
  import sad_pkg::*;

  localparam int unsigned ACC_W = acc_w(SUBBLKS);
  localparam int unsigned IDX_W = idx_w(NUM_CAND);

  logic             start;
  logic [SAD_W-1:0] sad_in;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start, sad_in, in_valid, out_ready,
    input  in_ready, best_sad, best_idx, out_valid
  );

  modport slave (
    input  start, sad_in, in_valid, out_ready,
    output in_ready, best_sad, best_idx, out_valid
  );

endinterface

// File: rtl/sad_min_cmp.sv
// Candidate-total vs running-best compare; the first candidate always wins.
module sad_min_cmp
  import sad_pkg::*;
#(
  parameter int unsigned ACC_W = 12
) (
  input  logic             first,
  input  logic [ACC_W-1:0] total,
  input  logic [ACC_W-1:0] best,
  output logic             take_new
);

  // Strict less-than so a tie keeps the earlier (lower-index) candidate.
  assign take_new = first | (total < best);

endmodule

// File: rtl/sad_min_search.sv
// Minimum-SAD search over NUM_CAND candidates of SUBBLKS 2x2 SADs each.
// Optional SAD_MIN_ZERO_EXIT_EN: a zero candidate total ends the search early.
module sad_min_search
  import sad_pkg::*;
#(
  parameter int unsigned SUBBLKS  = 4,
  parameter int unsigned NUM_CAND = 16
) (
  input  logic            clk,
  input  logic            rst,
  sad_min_search_if.slave bus
);

  localparam int unsigned ACC_W = acc_w(SUBBLKS);
  localparam int unsigned IDX_W = idx_w(NUM_CAND);
  localparam int unsigned SUB_W = (SUBBLKS > 1) ? $clog2(SUBBLKS) : 1;

  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] ACCUM = 2'(ST_ACCUM);
  localparam logic [1:0] DONE  = 2'(ST_DONE);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] total;
  logic [ACC_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  logic [SUB_W-1:0] sub_cnt;
  logic [IDX_W-1:0] cand_cnt;
  logic             in_ready;
  logic             out_valid;
  logic             beat;
  logic             last_sub;
  logic             last_cand;
  logic             zero_hit;
  logic             take_new;

  assign beat      = bus.in_valid & in_ready;
  assign last_sub  = (sub_cnt == SUB_W'(SUBBLKS - 1));
  assign last_cand = (cand_cnt == IDX_W'(NUM_CAND - 1));
  assign total     = acc + ACC_W'(bus.sad_in);

`ifdef SAD_MIN_ZERO_EXIT_EN
  assign zero_hit = (total == '0);
`else
  assign zero_hit = 1'b0;
`endif

  sad_min_cmp #(.ACC_W(ACC_W)) u_cmp (
    .first    (cand_cnt == '0),
    .total    (total),
    .best     (best_sad),
    .take_new (take_new)
  );

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ACCUM;
      ACCUM:   if (beat && last_sub && (last_cand || zero_hit)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered alongside the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ACCUM);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Accumulation, candidate counting and best tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      sub_cnt  <= '0;
      cand_cnt <= '0;
      best_sad <= '0;
      best_idx <= '0;
    end else if (state == IDLE && bus.start) begin
      acc      <= '0;
      sub_cnt  <= '0;
      cand_cnt <= '0;
    end else if (beat) begin
      if (last_sub) begin
        acc      <= '0;
        sub_cnt  <= '0;
        cand_cnt <= cand_cnt + IDX_W'(1);
        if (take_new) begin
          best_sad <= total;
          best_idx <= cand_cnt;
        end
      end else begin
        acc     <= total;
        sub_cnt <= sub_cnt + SUB_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.best_sad  = best_sad;
  assign bus.best_idx  = best_idx;

endmodule

// File: tb/tb_sad_min_search.sv
// Scoreboard bench for sad_min_search with SUBBLKS=4, NUM_CAND=4.
module tb_sad_min_search;

  typedef struct {
    int unsigned sad;
    int unsigned idx;
    int unsigned beats;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  exp_t exp_q[$];

  sad_min_search_if #(.SUBBLKS(4), .NUM_CAND(4)) bus ();

  sad_min_search #(.SUBBLKS(4), .NUM_CAND(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned v[16]);
    exp_t e;
    int unsigned tot;
    e.sad = 0;
    e.idx = 0;
    e.beats = 16;
    for (int unsigned c = 0; c < 4; c++) begin
      tot = 0;
      for (int unsigned s = 0; s < 4; s++) tot += v[c*4 + s];
      if (c == 0 || tot < e.sad) begin
        e.sad = tot;
        e.idx = c;
      end
`ifdef SAD_MIN_ZERO_EXIT_EN
      if (tot == 0) begin
        e.beats = (c + 1) * 4;
        break;
      end
`endif
    end
    return e;
  endfunction

  task automatic run_search(input int unsigned v[16], input bit gaps,
                            input int unsigned hold, input bit poke_start);
    exp_t e;
    int unsigned held_sad;
    int unsigned held_idx;
    e = model(v);
    exp_q.push_back(e);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk("in_ready_after_start", 32'(bus.in_ready), 1);
    for (int unsigned i = 0; i < e.beats; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      chk("out_valid_early", 32'(bus.out_valid), 0);
      bus.in_valid = 1'b1;
      bus.sad_in   = 10'(v[i]);
      bus.start    = poke_start && (i == 5);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk("out_valid_latency", 32'(bus.out_valid), 1);
    chk("in_ready_in_done", 32'(bus.in_ready), 0);
    held_sad = 32'(bus.best_sad);
    held_idx = 32'(bus.best_idx);
    for (int unsigned h = 0; h < hold; h++) begin
      bus.start = poke_start && (h == 1);
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_sad", 32'(bus.best_sad), held_sad);
      chk("hold_idx", 32'(bus.best_idx), held_idx);
    end
    bus.start = 1'b0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("best_sad", 32'(bus.best_sad), e.sad);
      chk("best_idx", 32'(bus.best_idx), e.idx);
    end
    bus.out_ready = 1'b1;
    bus.start     = poke_start;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk("idle_after_ack", 32'(bus.out_valid), 0);
    chk("start_at_ack_ignored", 32'(bus.in_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned v[16];
    bus.start     = 1'b0;
    bus.sad_in    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_best_sad", 32'(bus.best_sad), 0);
    chk("rst_best_idx", 32'(bus.best_idx), 0);
    rst = 1'b0;
    @(negedge clk);

    // Tie between candidates 1 and 2 keeps index 1.
    v = '{10, 10, 10, 10, 5, 5, 5, 5, 5, 5, 5, 5, 100, 0, 0, 0};
    run_search(v, 1'b0, 0, 1'b0);

    // Full-scale inputs must not overflow the accumulator.
    foreach (v[i]) v[i] = 1020;
    run_search(v, 1'b0, 0, 1'b0);

    // Input gaps and a stalled consumer give the same answer.
    v = '{10, 10, 10, 10, 5, 5, 5, 5, 5, 5, 5, 5, 100, 0, 0, 0};
    run_search(v, 1'b1, 5, 1'b0);

    // Abort after 7 beats, then restart.
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.sad_in   = 10'd50;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 0);
    chk("abort_best_sad", 32'(bus.best_sad), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_valid_later", 32'(bus.out_valid), 0);
    foreach (v[i]) v[i] = 3;
    run_search(v, 1'b0, 0, 1'b0);

    // Start pulses during ACCUM and DONE are ignored.
    v = '{30, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1, 1, 1, 2};
    run_search(v, 1'b0, 3, 1'b1);

    // Zero-total candidate at index 2.
    v = '{4, 4, 4, 4, 9, 9, 9, 9, 0, 0, 0, 0, 7, 7, 7, 7};
    run_search(v, 1'b0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
